// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg
//   Shared definitions for the bound flasher: phase codes, kick counter
//   width and a parameter legality check used at elaboration time.
//   Optional feature macro: BOUND_FLASHER_KICK_CNT_EN (see bound_flasher_gen).
package bound_flasher_pkg;

    localparam int KICK_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6
    } state_e;

    function automatic bit bounds_legal(input int led_w, input int b_lo,
                                        input int b_hi, input int step_div);
        return (led_w >= 3) && (b_lo > 0) && (b_lo < b_hi) &&
               (b_hi < led_w) && (step_div >= 1);
    endfunction

endpackage

// File: rtl/bound_flasher_step_tick_gen.sv
// step_tick_gen
//   Step prescaler: counts 0..STEP_DIV-1 and flags tick on the last count.
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   synchronous active-high reset
//     clr    in   hold the count at zero (flasher idle)
//     hold   in   freeze the count and suppress tick (pause)
//     tick   out  one step is due this clock
module step_tick_gen #(
    parameter int STEP_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = !hold && (cnt_q == LAST);

endmodule

// File: rtl/bound_flasher_gen.sv
// bound_flasher_gen
//   Thermometer LED bar sweeping a fixed multi-phase up/down pattern,
//   started by flick, with kickback on the UP2/UP3 turnarounds.
//   Ports:
//     clock     in   rising-edge clock
//     reset     in   synchronous active-high reset
//     flick     in   start / kickback request (level)
//     pause     in   freezes stepping while high
//     led_out   out  LED_W thermometer bar, led_out[i] = (i < level)
//     state     out  current phase code (state_e)
//     busy      out  phase is not IDLE
//     done      out  one-clock pulse on DN3 -> IDLE
//     kick_cnt  out  saturating count of kickbacks taken
//   Optional feature macro: BOUND_FLASHER_KICK_CNT_EN enables kick_cnt;
//   without it kick_cnt is tied to zero.
//
//   state | meaning
//   IDLE  | bar dark, waiting for flick
//   UP1   | rise to LED_W
//   DN1   | fall to B_LO
//   UP2   | rise to B_HI, flick at exit kicks back to DN1
//   DN2   | fall to 0
//   UP3   | rise to B_LO, flick at exit kicks back to DN2
//   DN3   | fall to 0, then done
module bound_flasher_gen
    import bound_flasher_pkg::*;
#(
    parameter int LED_W    = 16,
    parameter int B_LO     = 5,
    parameter int B_HI     = 10,
    parameter int STEP_DIV = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flick,
    input  logic                  pause,
    output logic [LED_W-1:0]      led_out,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  done,
    output logic [KICK_CNT_W-1:0] kick_cnt
);

    localparam int LW = $clog2(LED_W + 1);
    localparam logic [LW-1:0] L_FULL = LW'(LED_W);
    localparam logic [LW-1:0] L_LO   = LW'(B_LO);
    localparam logic [LW-1:0] L_HI   = LW'(B_HI);

    if (!bounds_legal(LED_W, B_LO, B_HI, STEP_DIV)) begin : g_bad_params
        $error("bound_flasher_gen: illegal LED_W/B_LO/B_HI/STEP_DIV");
    end

    state_e        state_q;
    logic [LW-1:0] lvl_q;
    logic          done_q;
    logic          tick;

    step_tick_gen #(.STEP_DIV(STEP_DIV)) u_step_tick_gen (
        .clock (clock),
        .reset (reset),
        .clr   (state_q == IDLE),
        .hold  (pause),
        .tick  (tick)
    );

    // Each turnaround spends one full tick at its target before the phase
    // changes, so the level dwells exactly one step at every bound.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (flick && !pause) state_q <= UP1;
                UP1: if (tick) begin
                    if (lvl_q != L_FULL) lvl_q <= lvl_q + 1'b1;
                    else                 state_q <= DN1;
                end
                DN1: if (tick) begin
                    if (lvl_q != L_LO) lvl_q <= lvl_q - 1'b1;
                    else               state_q <= UP2;
                end
                UP2: if (tick) begin
                    if (lvl_q != L_HI) lvl_q <= lvl_q + 1'b1;
                    else               state_q <= flick ? DN1 : DN2;
                end
                DN2: if (tick) begin
                    if (lvl_q != '0) lvl_q <= lvl_q - 1'b1;
                    else             state_q <= UP3;
                end
                UP3: if (tick) begin
                    if (lvl_q != L_LO) lvl_q <= lvl_q + 1'b1;
                    else               state_q <= flick ? DN2 : DN3;
                end
                DN3: if (tick) begin
                    if (lvl_q != '0) begin
                        lvl_q <= lvl_q - 1'b1;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    lvl_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        led_out = '0;
        for (int i = 0; i < LED_W; i++) begin
            led_out[i] = (i < int'(lvl_q));
        end
    end

    assign state = state_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

`ifdef BOUND_FLASHER_KICK_CNT_EN
    logic                  kick;
    logic [KICK_CNT_W-1:0] kick_cnt_q;

    // Mirrors the kickback branches of the FSM exit ticks.
    assign kick = tick && flick &&
                  (((state_q == UP2) && (lvl_q == L_HI)) ||
                   ((state_q == UP3) && (lvl_q == L_LO)));

    always_ff @(posedge clock) begin
        if (reset) begin
            kick_cnt_q <= '0;
        end else if (kick && (kick_cnt_q != '1)) begin
            kick_cnt_q <= kick_cnt_q + 1'b1;
        end
    end

    assign kick_cnt = kick_cnt_q;
`else
    assign kick_cnt = '0;
`endif

endmodule

// File: tb/tb_bound_flasher_gen.sv
module tb_bound_flasher_gen;

`ifdef BOUND_FLASHER_KICK_CNT_EN
    localparam int KC_EN = 1;
`else
    localparam int KC_EN = 0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // dut1: STEP_DIV=1, dut4: STEP_DIV=4
    logic        rst1, flick1, pause1, busy1, done1;
    logic [15:0] led1;
    logic [2:0]  st1;
    logic [7:0]  kc1;
    logic        rst4, flick4, pause4, busy4, done4;
    logic [15:0] led4;
    logic [2:0]  st4;
    logic [7:0]  kc4;

    int errors = 0;
    int checks = 0;

    bound_flasher_gen #(.LED_W(16), .B_LO(5), .B_HI(10), .STEP_DIV(1)) dut1 (
        .clock(clock), .reset(rst1), .flick(flick1), .pause(pause1),
        .led_out(led1), .state(st1), .busy(busy1), .done(done1), .kick_cnt(kc1)
    );

    bound_flasher_gen #(.LED_W(16), .B_LO(5), .B_HI(10), .STEP_DIV(4)) dut4 (
        .clock(clock), .reset(rst4), .flick(flick4), .pause(pause4),
        .led_out(led4), .state(st4), .busy(busy4), .done(done4), .kick_cnt(kc4)
    );

    function automatic logic [15:0] thermo(input int l);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) if (i < l) v[i] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst1 = 1; flick1 = 1; pause1 = 0;
        rst4 = 1; flick4 = 1; pause4 = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (led1 !== 16'h0000 || st1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || kc1 !== 8'd0) begin
                errors++;
                $display("FAIL reset1 c=%0d led=%h st=%0d busy=%b done=%b kc=%0d want 0000/0/0/0/0",
                         c, led1, st1, busy1, done1, kc1);
            end
            checks++;
            if (led4 !== 16'h0000 || st4 !== 3'd0 || busy4 !== 1'b0) begin
                errors++;
                $display("FAIL reset4 c=%0d led=%h st=%0d busy=%b want 0000/0/0", c, led4, st4, busy4);
            end
        end
        rst1 = 0; flick1 = 0;
        rst4 = 0; flick4 = 0;
    endtask

    task automatic test_full_sweep();
        int exp_st[$];
        int exp_l[$];
        int codes[6] = '{1, 2, 3, 4, 5, 6};
        int tgts[6]  = '{16, 5, 10, 0, 5, 0};
        int nexts[6] = '{2, 3, 4, 5, 6, 0};
        int l = 0;
        for (int p = 0; p < 6; p++) begin
            while (l != tgts[p]) begin
                l += (tgts[p] > l) ? 1 : -1;
                exp_st.push_back(codes[p]);
                exp_l.push_back(l);
            end
            exp_st.push_back(nexts[p]);
            exp_l.push_back(l);
        end
        checks++;
        if (exp_st.size() != 58) begin
            errors++;
            $display("FAIL sweep_len model=%0d want 58", exp_st.size());
        end
        flick1 = 1;
        @(negedge clock);
        flick1 = 0;
        checks++;
        if (st1 !== 3'd1 || led1 !== 16'h0000 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL start st=%0d led=%h busy=%b want 1/0000/1", st1, led1, busy1);
        end
        for (int k = 1; k <= 58; k++) begin
            @(negedge clock);
            checks++;
            if (st1 !== 3'(exp_st[k-1]) || led1 !== thermo(exp_l[k-1]) || done1 !== (k == 58)) begin
                errors++;
                $display("FAIL sweep k=%0d st=%0d led=%h done=%b want %0d/%h/%b",
                         k, st1, led1, done1, exp_st[k-1], thermo(exp_l[k-1]), (k == 58));
            end
        end
        @(negedge clock);
        checks++;
        if (st1 !== 3'd0 || done1 !== 1'b0 || busy1 !== 1'b0 || led1 !== 16'h0000) begin
            errors++;
            $display("FAIL sweep_end st=%0d done=%b busy=%b led=%h want 0/0/0/0000", st1, done1, busy1, led1);
        end
    endtask

    task automatic test_kick_up2();
        bit found = 0;
        flick1 = 1;
        @(negedge clock);
        flick1 = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (st1 === 3'd3 && led1 === 16'h03FF) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL kick2_wait st=%0d led=%h want UP2 at 03FF", st1, led1);
        end
        flick1 = 1;
        @(negedge clock);
        flick1 = 0;
        checks++;
        if (st1 !== 3'd2 || led1 !== 16'h03FF) begin
            errors++;
            $display("FAIL kick2_dn1 st=%0d led=%h want 2/03FF", st1, led1);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (st1 !== 3'd2 || led1 !== 16'h001F) begin
            errors++;
            $display("FAIL kick2_low st=%0d led=%h want 2/001F", st1, led1);
        end
        repeat (6) @(negedge clock);
        checks++;
        if (st1 !== 3'd3 || led1 !== 16'h03FF) begin
            errors++;
            $display("FAIL kick2_rise st=%0d led=%h want 3/03FF", st1, led1);
        end
        checks++;
        if (kc1 !== 8'(KC_EN)) begin
            errors++;
            $display("FAIL kick2_cnt kc=%0d want %0d", kc1, KC_EN);
        end
        @(negedge clock);
        checks++;
        if (st1 !== 3'd4 || led1 !== 16'h03FF) begin
            errors++;
            $display("FAIL kick2_noflick st=%0d led=%h want 4/03FF", st1, led1);
        end
    endtask

    task automatic test_kick_up3();
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (st1 === 3'd5 && led1 === 16'h001F) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL kick3_wait st=%0d led=%h want UP3 at 001F", st1, led1);
        end
        flick1 = 1;
        @(negedge clock);
        flick1 = 0;
        checks++;
        if (st1 !== 3'd4 || led1 !== 16'h001F) begin
            errors++;
            $display("FAIL kick3_dn2 st=%0d led=%h want 4/001F", st1, led1);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (st1 !== 3'd4 || led1 !== 16'h0000) begin
            errors++;
            $display("FAIL kick3_zero st=%0d led=%h want 4/0000", st1, led1);
        end
        @(negedge clock);
        checks++;
        if (st1 !== 3'd5 || led1 !== 16'h0000 || kc1 !== 8'(2 * KC_EN)) begin
            errors++;
            $display("FAIL kick3_up3 st=%0d led=%h kc=%0d want 5/0000/%0d", st1, led1, kc1, 2 * KC_EN);
        end
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (done1 === 1'b1) found = 1;
        end
        checks++;
        if (!found || st1 !== 3'd0) begin
            errors++;
            $display("FAIL kick3_done seen=%b st=%0d want 1/0", found, st1);
        end
    endtask

    task automatic test_pause();
        bit found = 0;
        flick4 = 1;
        @(negedge clock);
        flick4 = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (led4 === 16'h00FF) found = 1;
        end
        checks++;
        if (!found || st4 !== 3'd1) begin
            errors++;
            $display("FAIL pause_wait st=%0d led=%h want 1/00FF", st4, led4);
        end
        pause4 = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checks++;
            if (led4 !== 16'h00FF || st4 !== 3'd1) begin
                errors++;
                $display("FAIL pause_hold c=%0d st=%0d led=%h want 1/00FF", c, st4, led4);
            end
        end
        pause4 = 0;
        repeat (3) @(negedge clock);
        checks++;
        if (led4 !== 16'h00FF) begin
            errors++;
            $display("FAIL pause_early led=%h want 00FF", led4);
        end
        @(negedge clock);
        checks++;
        if (led4 !== 16'h01FF || st4 !== 3'd1) begin
            errors++;
            $display("FAIL pause_resume st=%0d led=%h want 1/01FF", st4, led4);
        end
        rst4 = 1;
        @(negedge clock);
        rst4 = 0;
        pause4 = 1; flick4 = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (st4 !== 3'd0 || busy4 !== 1'b0 || led4 !== 16'h0000) begin
                errors++;
                $display("FAIL pause_idle c=%0d st=%0d busy=%b led=%h want 0/0/0000", c, st4, busy4, led4);
            end
        end
        pause4 = 0; flick4 = 0;
        @(negedge clock);
        checks++;
        if (st4 !== 3'd0) begin
            errors++;
            $display("FAIL pause_idle_after st=%0d want 0", st4);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        bit saw_done = 0;
        flick1 = 1;
        @(negedge clock);
        flick1 = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            if (st1 === 3'd4 && led1 === 16'h007F) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_wait st=%0d led=%h want DN2 at 007F", st1, led1);
        end
        rst1 = 1;
        @(negedge clock);
        rst1 = 0;
        checks++;
        if (led1 !== 16'h0000 || st1 !== 3'd0 || busy1 !== 1'b0 || kc1 !== 8'd0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid led=%h st=%0d busy=%b kc=%0d done=%b want 0000/0/0/0/0",
                     led1, st1, busy1, kc1, done1);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (done1 !== 1'b0 || st1 !== 3'd0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL rstmid_quiet done/state activity after reset, want none");
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_kick_up2();
        test_kick_up3();
        test_pause();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
